// File: rtl/mips_harvard_bus_bridge.sv
// mips_harvard_bus_bridge: runs a Harvard MIPS core on one shared Avalon-style bus, one instruction at a time.
// Optional one-entry instruction buffer: define MIPS_BRIDGE_IFETCH_BUF_EN.
module mips_harvard_bus_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_active,
    output logic                core_clk_enable,
    input  logic [ADDR_W-1:0]   core_instr_address,
    output logic [DATA_W-1:0]   core_instr_readdata,
    input  logic [ADDR_W-1:0]   core_data_address,
    input  logic                core_data_read,
    input  logic                core_data_write,
    input  logic [DATA_W-1:0]   core_data_writedata,
    output logic [DATA_W-1:0]   core_data_readdata,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,
    output logic                busy,
    output logic                bus_error
);

    localparam int BE_W  = DATA_W / 8;
    localparam int LSB_W = (BE_W > 1) ? $clog2(BE_W) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {S_FETCH, S_DATA, S_COMMIT, S_HALT, S_ERROR} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic              read_s, write_s, clk_en_s;
    logic              instr_load, data_load, err_set;
    logic [ADDR_W-1:0] address_s;
    logic [DATA_W-1:0] writedata_s;
    logic              instr_misaligned, data_misaligned, timeout_hit, buf_hit;

    assign instr_misaligned = (BE_W > 1) && (core_instr_address[LSB_W-1:0] != '0);
    assign data_misaligned  = (BE_W > 1) && (core_data_address[LSB_W-1:0] != '0);
    // The counter reaches TIMEOUT at this edge, so the strobe is gone in the following cycle.
    assign timeout_hit      = (TIMEOUT > 0) && waitrequest && (wait_cnt == CNT_LAST);

`ifdef MIPS_BRIDGE_IFETCH_BUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;

    // A completed write to the buffered address invalidates it so modified code is refetched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
        end else if (state == S_ERROR || err_set) begin
            buf_valid <= 1'b0;
        end else if (instr_load) begin
            buf_valid <= 1'b1;
            buf_tag   <= core_instr_address;
        end else if (state == S_DATA && write_s && !waitrequest && core_data_address == buf_tag) begin
            buf_valid <= 1'b0;
        end
    end

    assign buf_hit = buf_valid && (core_instr_address == buf_tag);
`else
    assign buf_hit = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        read_s      = 1'b0;
        write_s     = 1'b0;
        clk_en_s    = 1'b0;
        instr_load  = 1'b0;
        data_load   = 1'b0;
        err_set     = 1'b0;
        address_s   = '0;
        writedata_s = '0;
        case (state)
            S_FETCH: begin
                if (!core_active) begin
                    state_next = S_HALT;
                end else if (buf_hit) begin
                    state_next = S_DATA;
                end else if (instr_misaligned) begin
                    err_set    = 1'b1;
                    state_next = S_ERROR;
                end else begin
                    read_s    = 1'b1;
                    address_s = core_instr_address;
                    if (!waitrequest) begin
                        instr_load = 1'b1;
                        state_next = S_DATA;
                    end else if (timeout_hit) begin
                        err_set    = 1'b1;
                        state_next = S_ERROR;
                    end
                end
            end
            S_DATA: begin
                // Without a data request the commit strobe is issued here, saving a cycle.
                if (core_data_write || core_data_read) begin
                    if (data_misaligned) begin
                        err_set    = 1'b1;
                        state_next = S_ERROR;
                    end else begin
                        address_s = core_data_address;
                        if (core_data_write) begin
                            write_s     = 1'b1;
                            writedata_s = core_data_writedata;
                        end else begin
                            read_s = 1'b1;
                        end
                        if (!waitrequest) begin
                            data_load  = !core_data_write;
                            state_next = S_COMMIT;
                        end else if (timeout_hit) begin
                            err_set    = 1'b1;
                            state_next = S_ERROR;
                        end
                    end
                end else begin
                    clk_en_s   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_COMMIT: begin
                clk_en_s   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= S_FETCH;
            wait_cnt            <= '0;
            core_instr_readdata <= '0;
            core_data_readdata  <= '0;
            bus_error           <= 1'b0;
        end else begin
            state <= state_next;
            if ((read_s || write_s) && waitrequest) wait_cnt <= wait_cnt + 1'b1;
            else                                    wait_cnt <= '0;
            if (instr_load) core_instr_readdata <= readdata;
            if (data_load)  core_data_readdata  <= readdata;
            if (err_set)    bus_error           <= 1'b1;
        end
    end

    // Gating with reset makes the strobes fall the moment reset is asserted.
    assign read            = reset & read_s;
    assign write           = reset & write_s;
    assign core_clk_enable = reset & clk_en_s;
    assign address         = reset ? address_s : '0;
    assign writedata       = reset ? writedata_s : '0;
    assign byteenable      = (read || write) ? '1 : '0;
    assign busy            = reset && (state == S_FETCH || state == S_DATA || state == S_COMMIT);

endmodule

// File: tb/tb_mips_harvard_bus_bridge.sv
// tb_mips_harvard_bus_bridge: randomized self-checking bench; the bench plays both the core and the memory.
module tb_mips_harvard_bus_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
`ifdef MIPS_BRIDGE_IFETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              core_active;
    logic              core_clk_enable;
    logic [ADDR_W-1:0] core_instr_address;
    logic [DATA_W-1:0] core_instr_readdata;
    logic [ADDR_W-1:0] core_data_address;
    logic              core_data_read;
    logic              core_data_write;
    logic [DATA_W-1:0] core_data_writedata;
    logic [DATA_W-1:0] core_data_readdata;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              busy;
    logic              bus_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    bit          mv;
    logic [31:0] mt;
    logic [31:0] exp_ireg, exp_dreg;

    typedef struct {
        int          cycles;
        bit          committed;
        int          f_rd;
        int          d_rd;
        int          d_wr;
        int          other;
        bit          hold_ok;
        bit          conflict;
        bit          seen;
        logic [31:0] first_addr;
        bit          first_rd;
    } obs_t;

    mips_harvard_bus_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .core_active(core_active), .core_clk_enable(core_clk_enable),
        .core_instr_address(core_instr_address), .core_instr_readdata(core_instr_readdata),
        .core_data_address(core_data_address), .core_data_read(core_data_read),
        .core_data_write(core_data_write), .core_data_writedata(core_data_writedata),
        .core_data_readdata(core_data_readdata), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .busy(busy), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Reference model of one instruction: predicts whether a fetch goes on the bus and the registered read data.
    task automatic model_step(input logic [31:0] pc, input logic [1:0] kind, input logic [31:0] daddr,
                              output bit fetch);
        fetch = !(BUF_EN && mv && mt == pc);
        if (fetch) begin
            exp_ireg = memval(pc);
            mv = 1'b1;
            mt = pc;
        end
        if (kind == 2'd1) exp_dreg = memval(daddr);
        if (kind[1] && mv && daddr == mt) mv = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        waitrequest = 1'b0;
        core_active = 1'b1;
        core_data_read = 1'b0;
        core_data_write = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mv = 1'b0;
        exp_ireg = '0;
        exp_dreg = '0;
    endtask

    // Plays core and memory for one instruction, called at a negedge; returns at a negedge.
    task automatic run_instr(input logic [31:0] pc, input logic [1:0] kind, input logic [31:0] daddr,
                             input logic [31:0] wdata, input int fwait, input int dwait,
                             input bit exp_fetch, output obs_t o);
        int acc, wleft;
        bit first;
        logic [31:0] h_addr;
        logic h_rd;
        o = '{cycles: -1, committed: 0, f_rd: 0, d_rd: 0, d_wr: 0, other: 0, hold_ok: 1,
              conflict: 0, seen: 0, first_addr: '0, first_rd: 0};
        core_active = 1'b1;
        core_instr_address = pc;
        core_data_read = kind[0];
        core_data_write = kind[1];
        core_data_address = daddr;
        core_data_writedata = wdata;
        acc = exp_fetch ? 0 : 1;
        wleft = exp_fetch ? fwait : dwait;
        first = 1'b1;
        h_addr = '0;
        h_rd = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (read && write) o.conflict = 1'b1;
            if (read || write) begin
                if (byteenable !== {(DATA_W/8){1'b1}}) o.conflict = 1'b1;
                if (!o.seen) begin
                    o.seen = 1'b1;
                    o.first_addr = address;
                    o.first_rd = read;
                end
                if (first) begin
                    h_addr = address;
                    h_rd = read;
                    first = 1'b0;
                end else if (address !== h_addr || read !== h_rd) begin
                    o.hold_ok = 1'b0;
                end
                if (acc == 0 && read && address == pc) o.f_rd++;
                else if (acc == 1 && write && address == daddr && writedata == wdata) o.d_wr++;
                else if (acc == 1 && read && address == daddr) o.d_rd++;
                else o.other++;
                readdata = memval(address);
                if (wleft > 0) begin
                    waitrequest = 1'b1;
                    wleft--;
                end else begin
                    waitrequest = 1'b0;
                    if (write) mem[address] = writedata;
                    acc++;
                    wleft = dwait;
                    first = 1'b1;
                end
            end else begin
                waitrequest = 1'b0;
                readdata = $urandom;
            end
            if (core_clk_enable) begin
                o.committed = 1'b1;
                o.cycles = c + 1;
                @(negedge clk);
                break;
            end
            if (bus_error) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        core_active = 1'b1;
        core_instr_address = RESET_VEC;
        core_data_writedata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({read, write, core_clk_enable, busy, bus_error} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b, want 00000", {read, write, core_clk_enable, busy, bus_error});
        end
        checks++;
        if (address !== '0 || writedata !== '0 || byteenable !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got addr=%h wdata=%h be=%h, want all 0", address, writedata, byteenable);
        end
        checks++;
        if (core_instr_readdata !== '0 || core_data_readdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got instr=%h data=%h, want 0", core_instr_readdata, core_data_readdata);
        end
    endtask

    task automatic test_program();
        obs_t o;
        bit fetch;
        logic [31:0] pc, daddr, wdata;
        logic [1:0] kind;
        int r, fw, dw, exp_cyc;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            pc = RESET_VEC + 32'(4 * $urandom_range(0, 3));
            r = $urandom_range(0, 9);
            kind = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            daddr = ($urandom_range(0, 3) == 0) ? RESET_VEC + 32'(4 * $urandom_range(0, 3))
                                                : 32'h1000_0000 + 32'(4 * $urandom_range(0, 7));
            wdata = $urandom;
            fw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            model_step(pc, kind, daddr, fetch);
            exp_cyc = 1 + (fetch ? fw : 0) + ((kind != 2'd0) ? 2 + dw : 1);
            run_instr(pc, kind, daddr, wdata, fw, dw, fetch, o);
            checks++;
            if (!o.committed || o.cycles != exp_cyc) begin
                errors++;
                $display("[TB] FAIL latency[%0d]: got %0d cycles (commit=%0b), want %0d", i, o.cycles, o.committed, exp_cyc);
            end
            checks++;
            if (o.f_rd != (fetch ? fw + 1 : 0)) begin
                errors++;
                $display("[TB] FAIL fetch[%0d]: got %0d read cycles, want %0d", i, o.f_rd, fetch ? fw + 1 : 0);
            end
            checks++;
            if (o.d_wr != (kind[1] ? dw + 1 : 0) || o.d_rd != ((kind == 2'd1) ? dw + 1 : 0) || o.other != 0) begin
                errors++;
                $display("[TB] FAIL data_access[%0d]: got wr=%0d rd=%0d other=%0d, want wr=%0d rd=%0d other=0",
                         i, o.d_wr, o.d_rd, o.other, kind[1] ? dw + 1 : 0, (kind == 2'd1) ? dw + 1 : 0);
            end
            checks++;
            if (!o.hold_ok || o.conflict) begin
                errors++;
                $display("[TB] FAIL protocol[%0d]: got hold_ok=%0b conflict=%0b, want 1/0", i, o.hold_ok, o.conflict);
            end
            checks++;
            if (core_instr_readdata !== exp_ireg || core_data_readdata !== exp_dreg) begin
                errors++;
                $display("[TB] FAIL readdata[%0d]: got instr=%h data=%h, want instr=%h data=%h",
                         i, core_instr_readdata, core_data_readdata, exp_ireg, exp_dreg);
            end
        end
        checks++;
        if (bus_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL program_bus_error: got %b, want 0", bus_error);
        end
    endtask

    task automatic test_stall4();
        obs_t o;
        bit fetch;
        do_reset();
        model_step(RESET_VEC, 2'd0, '0, fetch);
        run_instr(RESET_VEC, 2'd0, '0, '0, 4, 0, fetch, o);
        checks++;
        if (o.f_rd != 5 || !o.hold_ok || o.other != 0) begin
            errors++;
            $display("[TB] FAIL stall4_hold: got %0d read cycles hold_ok=%0b, want 5 and 1", o.f_rd, o.hold_ok);
        end
        checks++;
        if (o.cycles != 6) begin
            errors++;
            $display("[TB] FAIL stall4_latency: got %0d cycles, want 6", o.cycles);
        end
    endtask

    task automatic test_ifetch_buf();
        obs_t o;
        bit fetch;
        logic [31:0] loop_pc;
        loop_pc = 32'hBFC0_0010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            model_step(loop_pc, (i == 2) ? 2'd2 : 2'd0, loop_pc, fetch);
            run_instr(loop_pc, (i == 2) ? 2'd2 : 2'd0, loop_pc, 32'h2400_1234, 0, 0, fetch, o);
            checks++;
            if (o.f_rd != (fetch ? 1 : 0) || !o.committed) begin
                errors++;
                $display("[TB] FAIL ifetch_buf[%0d]: got %0d fetch reads commit=%0b, want %0d", i, o.f_rd, o.committed, fetch ? 1 : 0);
            end
        end
        checks++;
        if (core_instr_readdata !== 32'h2400_1234) begin
            errors++;
            $display("[TB] FAIL ifetch_refetch: got %h, want 24001234", core_instr_readdata);
        end
    endtask

    task automatic test_timeout();
        int rd_cnt, bad;
        do_reset();
        core_instr_address = RESET_VEC;
        rd_cnt = 0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!read) break;
            rd_cnt++;
            if (address !== RESET_VEC) bad++;
            waitrequest = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (rd_cnt != TIMEOUT || bad != 0 || bus_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout: got %0d read cycles bad_addr=%0d bus_error=%b, want %0d 0 1", rd_cnt, bad, bus_error, TIMEOUT);
        end
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (core_clk_enable || read || write || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL timeout_terminal: got %0d active cycles, want 0", bad);
        end
        waitrequest = 1'b0;
    endtask

    task automatic test_misaligned();
        obs_t o;
        bit fetch;
        do_reset();
        model_step(RESET_VEC, 2'd1, 32'h0000_0002, fetch);
        run_instr(RESET_VEC, 2'd1, 32'h0000_0002, '0, 0, 0, fetch, o);
        checks++;
        if (o.committed || o.f_rd != 1 || o.d_rd != 0 || o.other != 0) begin
            errors++;
            $display("[TB] FAIL misaligned_strobe: got commit=%0b fetch=%0d drd=%0d other=%0d, want 0 1 0 0",
                     o.committed, o.f_rd, o.d_rd, o.other);
        end
        #1;
        checks++;
        if (bus_error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misaligned_error: got bus_error=%b busy=%b, want 1 0", bus_error, busy);
        end
    endtask

    task automatic test_reset_mid_write();
        obs_t o;
        bit fetch;
        do_reset();
        core_instr_address = RESET_VEC + 32'd8;
        core_data_write = 1'b1;
        core_data_address = 32'h1000_0040;
        core_data_writedata = 32'hCAFE_F00D;
        #1;
        readdata = memval(address);
        waitrequest = 1'b0;
        @(negedge clk);
        #1;
        waitrequest = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stalled_write: got write=%b, want 1", write);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (write !== 1'b0 || read !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_drop: got write=%b read=%b busy=%b, want 0 0 0", write, read, busy);
        end
        @(negedge clk);
        waitrequest = 1'b0;
        reset = 1'b1;
        mv = 1'b0;
        exp_ireg = '0;
        exp_dreg = '0;
        model_step(RESET_VEC, 2'd0, '0, fetch);
        run_instr(RESET_VEC, 2'd0, '0, '0, 0, 0, fetch, o);
        checks++;
        if (!o.first_rd || o.first_addr !== RESET_VEC || o.d_wr != 0 || o.other != 0 || !o.committed) begin
            errors++;
            $display("[TB] FAIL post_reset_fetch: got rd=%0b addr=%h wr=%0d other=%0d, want 1 %h 0 0",
                     o.first_rd, o.first_addr, o.d_wr, o.other, RESET_VEC);
        end
    endtask

    task automatic test_halt();
        int act;
        do_reset();
        core_active = 1'b0;
        core_data_read = 1'b1;
        act = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (read || write || core_clk_enable) act++;
            @(negedge clk);
        end
        core_active = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (read || write || core_clk_enable) act++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (act != 0 || busy !== 1'b0 || bus_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt: got %0d active cycles busy=%b bus_error=%b, want 0 0 0", act, busy, bus_error);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        core_active = 1'b1;
        core_instr_address = '0;
        core_data_address = '0;
        core_data_read = 1'b0;
        core_data_write = 1'b0;
        core_data_writedata = '0;
        waitrequest = 1'b0;
        readdata = '0;
        mv = 1'b0;
        mt = '0;
        exp_ireg = '0;
        exp_dreg = '0;
        @(negedge clk);
        test_reset();
        test_program();
        test_stall4();
        test_ifetch_buf();
        test_timeout();
        test_misaligned();
        test_reset_mid_write();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
